// File: rtl/id_ex_stage_pipe.sv
// id_ex_stage_pipe
//
// Decode->execute pipeline stage register with a valid/ready handshake,
// hazard stall, flush and two saturating perf counters. The control payload
// is zeroed whenever the slot holds no instruction, so a killed or bubbled
// slot behaves as a NOP. The datapath payload is only loaded with real
// instructions and is otherwise held.
//
// Handshake: an input transfer happens on a rising edge where
// in_valid & in_ready; an output transfer happens on a rising edge where
// out_valid & out_ready & ~stall. A flush discards any input transfer of the
// same cycle.
//
// Configuration macro: PIPE_SKID_EN
//   defined   : 1-entry skid buffer, in_ready comes straight from a flop
//               (~skid valid); no in_ready <- out_ready combinational path.
//   undefined : no skid, in_ready = ~stall & (~out_valid | out_ready).
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake
//   in_ctrl, in_data      control / datapath payload from decode
//   stall, flush          hazard unit controls (flush wins over stall)
//   out_valid/out_ready   downstream handshake
//   out_ctrl, out_data    registered payloads
//   bubble_cnt            cycles a bubble entered the stage (saturating)
//   flush_cnt             flushes that killed at least one valid entry (saturating)

module id_ex_stage_pipe #(
    parameter int CTRL_W = 32,
    parameter int DATA_W = 180,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic [CNT_W-1:0]  flushc_q, flushc_d;
    logic              skid_valid;
    logic              main_load;

    // Main register may take a new entry: not stalled, and either empty or
    // its current entry leaves this cycle.
    assign main_load = ~stall & (~valid_q | out_ready);

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire;

    assign skid_valid = skid_valid_q;
    assign in_ready   = ~skid_valid_q;
    assign in_fire    = in_valid & in_ready;
`else
    assign skid_valid = 1'b0;
    assign in_ready   = main_load;
`endif

    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        data_d   = data_q;
        bubble_d = bubble_q;
        flushc_d = flushc_q;
`ifdef PIPE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
`ifdef PIPE_SKID_EN
            skid_valid_d = 1'b0;
`endif
            if (valid_q | skid_valid) begin
                flushc_d = sat_inc(flushc_q);
            end
        end else if (main_load) begin
`ifdef PIPE_SKID_EN
            // A parked entry is older than anything upstream, so it goes first.
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end else
`endif
            if (in_valid) begin
                valid_d = 1'b1;
                ctrl_d  = in_ctrl;
                data_d  = in_data;
            end else begin
                valid_d  = 1'b0;
                ctrl_d   = '0;
                bubble_d = sat_inc(bubble_q);
            end
        end
`ifdef PIPE_SKID_EN
        // Accepted while the main register cannot take it: park it.
        else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            data_q   <= '0;
            bubble_q <= '0;
            flushc_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            data_q   <= data_d;
            bubble_q <= bubble_d;
            flushc_q <= flushc_d;
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`endif

    assign out_valid  = valid_q;
    assign out_ctrl   = ctrl_q;
    assign out_data   = data_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flushc_q;

    // An empty slot must always look like a NOP downstream.
    a_ctrl_zero_when_empty: assert property (
        @(posedge clk) disable iff (rst) (!valid_q |-> (ctrl_q == '0))
    );

endmodule

// File: tb/tb_id_ex_stage_pipe.sv
module tb_id_ex_stage_pipe;
    localparam int CW = 32;
    localparam int DW = 180;
    localparam int NW = 16;

    // clock / reset / DUT
    logic          clk;
    logic          rst;
    logic          in_valid, stall, flush, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] bubble_cnt, flush_cnt;
    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_bubble_cnt, s_flush_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_pipe #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy driven by the same inputs, for saturation.
    id_ex_stage_pipe #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
        .out_data(s_out_data), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wide data pattern derived from a 32-bit tag (touches both ends of the bus).
    function automatic logic [DW-1:0] wd(input logic [31:0] x);
        return {x, {(DW-64){1'b0}}, ~x};
    endfunction

    // Vector table
    typedef struct {
        logic          iv;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic          st, fl, ordy;
        logic          e_irdy;
        logic          e_ov;
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_data;
        logic [NW-1:0] e_bub, e_fl;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [31:0] c, input logic st,
                                input logic fl, input logic ordy, input logic irdy,
                                input logic eov, input logic [31:0] ec, input logic [31:0] ed,
                                input int eb, input int ef);
        vec_t v;
        v.iv = iv; v.ctrl = c; v.data = wd(c); v.st = st; v.fl = fl; v.ordy = ordy;
        v.e_irdy = irdy; v.e_ov = eov; v.e_ctrl = ec; v.e_data = wd(ed);
        v.e_bub = NW'(eb); v.e_fl = NW'(ef);
        return v;
    endfunction

    vec_t tbl[14];

    // Stream driver / scoreboard state
    logic [CW-1:0] items[8];
    int            n_items;
    int            item_idx;
    int            n_consumed;
    logic          pre_irdy;
    logic [CW-1:0] exp_q[$];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_data = '0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        rst = 1'b0;
        item_idx = 0; n_items = 0; n_consumed = 0;
        exp_q.delete();
    endtask

    // One clock of handshake-following stimulus: starts and ends at a negedge.
    task automatic run_cycle(input logic st, input logic fl, input logic ordy);
        logic [CW-1:0] e;
        stall = st; flush = fl; out_ready = ordy;
        if (item_idx < n_items) begin
            in_valid = 1'b1; in_ctrl = items[item_idx]; in_data = wd(items[item_idx]);
        end else begin
            in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        end
        #1;
        pre_irdy = in_ready;
        if (out_valid && ordy && !st && !fl) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", out_ctrl, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_ctrl", out_ctrl, e);
                check("sb_data", out_data, wd(e));
                n_consumed++;
            end
        end
        if (in_valid && in_ready && !fl) begin
            exp_q.push_back(items[item_idx]);
            item_idx++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_ir;
        rst = 1'b1;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_data = '0;

        //            iv  ctrl  st fl rd  irdy ov  ctrl  data  bub fl
        tbl[0]  = mk(1, 'h11, 0, 0, 1,  1,  1, 'h11, 'h11, 0, 0);
        tbl[1]  = mk(1, 'h22, 0, 0, 1,  1,  1, 'h22, 'h22, 0, 0);
        tbl[2]  = mk(1, 'h33, 0, 0, 1,  1,  1, 'h33, 'h33, 0, 0);
        tbl[3]  = mk(0, 'h00, 1, 0, 1,  0,  1, 'h33, 'h33, 0, 0);
        tbl[4]  = mk(0, 'h00, 1, 0, 1,  0,  1, 'h33, 'h33, 0, 0);
        tbl[5]  = mk(0, 'h00, 0, 0, 0,  0,  1, 'h33, 'h33, 0, 0);
        tbl[6]  = mk(1, 'h44, 0, 1, 0,  0,  0, 'h00, 'h33, 0, 1);
        tbl[7]  = mk(0, 'h00, 0, 0, 0,  1,  0, 'h00, 'h33, 1, 1);
        tbl[8]  = mk(1, 'h55, 0, 0, 0,  1,  1, 'h55, 'h55, 1, 1);
        tbl[9]  = mk(0, 'h00, 0, 1, 1,  1,  0, 'h00, 'h55, 1, 2);
        tbl[10] = mk(0, 'h00, 0, 1, 1,  1,  0, 'h00, 'h55, 1, 2);
        tbl[11] = mk(0, 'h00, 0, 0, 1,  1,  0, 'h00, 'h55, 2, 2);
        tbl[12] = mk(0, 'h00, 1, 0, 1,  0,  0, 'h00, 'h55, 2, 2);
        tbl[13] = mk(1, 'h77, 0, 0, 1,  1,  1, 'h77, 'h77, 2, 2);

        // Table-driven vectors
        do_reset();
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].iv; in_ctrl = tbl[i].ctrl; in_data = tbl[i].data;
            stall = tbl[i].st; flush = tbl[i].fl; out_ready = tbl[i].ordy;
            #1;
            exp_ir = tbl[i].e_irdy;
`ifdef PIPE_SKID_EN
            exp_ir = 1'b1;
`endif
            check($sformatf("tbl%0d_in_ready", i), in_ready, exp_ir);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            check($sformatf("tbl%0d_out_ctrl", i), out_ctrl, tbl[i].e_ctrl);
            check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
            check($sformatf("tbl%0d_bubble_cnt", i), bubble_cnt, tbl[i].e_bub);
            check($sformatf("tbl%0d_flush_cnt", i), flush_cnt, tbl[i].e_fl);
            @(negedge clk);
        end

        // Stall with a stream behind it: nothing lost, order kept
        do_reset();
        items[0] = 'h22; items[1] = 'h33; items[2] = 'h44; n_items = 3;
        run_cycle(0, 0, 1);
        check("stall_pre_ctrl", out_ctrl, 'h22);
        for (int k = 0; k < 3; k++) begin
            run_cycle(1, 0, 1);
            check($sformatf("stall%0d_out_valid", k), out_valid, 1);
            check($sformatf("stall%0d_out_ctrl", k), out_ctrl, 'h22);
            check($sformatf("stall%0d_out_data", k), out_data, wd('h22));
`ifndef PIPE_SKID_EN
            check($sformatf("stall%0d_in_ready", k), pre_irdy, 0);
`else
            if (k > 0) check($sformatf("stall%0d_in_ready", k), pre_irdy, 0);
`endif
        end
        run_cycle(0, 0, 1);
        check("stall_release_B", out_ctrl, 'h33);
        run_cycle(0, 0, 1);
        check("stall_release_C", out_ctrl, 'h44);
        run_cycle(0, 0, 1);
        run_cycle(0, 0, 1);
        check("stall_consumed", n_consumed, 3);
        check("stall_accepted", item_idx, 3);

        // Downstream blocked while two entries are offered
        do_reset();
        items[0] = 'hA1; items[1] = 'hB2; n_items = 2;
        run_cycle(0, 0, 0);
        check("blk_main_A", out_ctrl, 'hA1);
        run_cycle(0, 0, 0);
        check("blk_hold_A", out_ctrl, 'hA1);
        check("blk_in_ready_low", in_ready, 0);
`ifdef PIPE_SKID_EN
        check("blk_B_in_skid", item_idx, 2);
`endif
        run_cycle(0, 0, 1);
        check("blk_main_B", out_ctrl, 'hB2);
        check("blk_in_ready_high", in_ready, 1);
        run_cycle(0, 0, 1);
        check("blk_consumed", n_consumed, 2);
        check("blk_queue_empty", exp_q.size(), 0);

        // Asynchronous reset mid-stream, away from any clock edge
        items[2] = 'hC3; n_items = 3;
        run_cycle(0, 0, 0);
        check("arst_pre_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_ctrl", out_ctrl, 0);
        check("arst_out_data", out_data, 0);
        check("arst_bubble_cnt", bubble_cnt, 0);
        check("arst_flush_cnt", flush_cnt, 0);
        stall = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);

        // Bubble counting and saturation
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_cycle(0, 0, 1);
            check($sformatf("bub%0d_out_ctrl", k), out_ctrl, 0);
            check($sformatf("bub%0d_out_valid", k), out_valid, 0);
        end
        check("bub4_count", bubble_cnt, 4);
        check("bub4_count_narrow", s_bubble_cnt, 4);
        for (int k = 0; k < 16; k++) run_cycle(0, 0, 1);
        check("bub20_count", bubble_cnt, 20);
        check("bub20_saturated", s_bubble_cnt, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
